// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// INST_NOP is also what decode uses when it flushes to a bubble.
package fetch_stage_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs for the IF/ID boundary.
// The head is read straight from registers; a push into an empty buffer shows up next cycle.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fb_entry_t                push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output fb_entry_t                head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fb_entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full buffer may still take a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests,
// buffers responses and drops those made stale by an execute redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int CNT_W = $clog2(FB_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] fb_count;
  logic             fb_full, fb_empty;
  fb_entry_t        fb_head, fb_push_data;
  logic             fb_push, fb_pop;
  logic [CNT_W:0]   credits_used;
  logic             handshake, discard;

  // Slots already claimed: buffered entries plus responses that will still be kept.
  assign credits_used = {1'b0, fb_count} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign imem_req     = !rst && !redirect_valid && (credits_used < (CNT_W+1)'(FB_DEPTH));
  assign imem_addr    = pc_q;
  assign handshake    = imem_req && imem_gnt;

  // Every kept in-flight request is contiguous and ends at pc_q-4, so the oldest one's PC
  // is pc_q minus four per outstanding request.
  assign discard           = imem_rvalid && ((drop_q != '0) || redirect_valid);
  assign fb_push           = imem_rvalid && !discard;
  assign fb_push_data.pc   = pc_q - (32'(inflight_q) << 2);
  assign fb_push_data.inst = imem_rdata;
  assign fb_pop            = !fb_empty && !stall && !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CNT_W'(handshake) - CNT_W'(imem_rvalid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d   = word_align(redirect_pc);
      drop_d = inflight_q - CNT_W'(imem_rvalid);
    end else begin
      if (handshake) pc_d = pc_q + 32'd4;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_buffer #(
    .DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fb_push),
    .push_data_i (fb_push_data),
    .pop_i       (fb_pop),
    .flush_i     (redirect_valid),
    .full_o      (fb_full),
    .empty_o     (fb_empty),
    .count_o     (fb_count),
    .head_o      (fb_head)
  );

  assign if_valid       = !fb_empty;
  assign if_instruction = if_valid ? fb_head.inst : INST_NOP;
  assign if_pc          = if_valid ? fb_head.pc : 32'd0;
  assign if_pc_plus4    = if_pc + 32'd4;

  a_inflight_max:  assert property (@(posedge clk) disable iff (rst) inflight_q <= CNT_W'(FB_DEPTH));
  a_drop_le_infl:  assert property (@(posedge clk) disable iff (rst) drop_q <= inflight_q);
  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(fb_push && fb_full && !fb_pop));
  a_no_spurious_r: assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && inflight_q == '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with fixed latency plus a program-order
// reference of which PCs must be fetched and delivered, under directed and random stimulus.
module tb_fetch_stage;

  localparam int          FB_DEPTH = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;

  fetch_stage #(.RESET_PC(32'h0), .FB_DEPTH(FB_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          checks = 0, failures = 0, cyc = 0, lat = 1, gnt_mode = 0;
  logic        rst_v = 1'b1, stall_v = 1'b0, redir_v = 1'b0;
  logic [31:0] redir_pc_v = 32'h0;
  logic [31:0] exp_pc = 32'h0, fetch_exp = 32'h0, held_addr = 32'h0;
  logic        hold_pending = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs for this cycle (called at the falling edge) and decide the grant.
  task automatic begin_cycle();
    rst            = rst_v;
    stall          = stall_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (!rst_v) chk("outstanding", {31'b0, memq.size() <= FB_DEPTH}, 32'd1);
    if (!rst_v && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(memq[0].addr);
      void'(memq.pop_front());
    end
    #1;
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      1:       imem_gnt = ($urandom_range(3) != 0);
      default: imem_gnt = 1'b0;
    endcase
    #1;
  endtask

  // Reference checks, model update, then advance to the next falling edge.
  task automatic end_cycle();
    if (rst_v) begin
      chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    end else begin
      if (redir_v) chk("req_on_redirect", {31'b0, imem_req}, 32'd0);
      if (hold_pending && !redir_v) begin
        chk("req_held", {31'b0, imem_req}, 32'd1);
        chk("addr_held", imem_addr, held_addr);
      end
      if (imem_req) chk("fetch_addr", imem_addr, fetch_exp);
      chk("pc_plus4", if_pc_plus4, if_pc + 32'd4);
      if (if_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_inst", if_instruction, inst_of(exp_pc));
      end else begin
        chk("idle_inst", if_instruction, NOP);
        chk("idle_pc", if_pc, 32'd0);
      end
    end

    if (rst_v) begin
      memq.delete();
      exp_pc       = 32'h0;
      fetch_exp    = 32'h0;
      hold_pending = 1'b0;
    end else begin
      if (imem_req && imem_gnt) begin
        memq.push_back('{addr: imem_addr, due: cyc + lat});
        fetch_exp = fetch_exp + 32'd4;
      end
      if (redir_v) begin
        fetch_exp = {redir_pc_v[31:2], 2'b00};
        exp_pc    = {redir_pc_v[31:2], 2'b00};
      end else if (if_valid && !stall_v) begin
        exp_pc = exp_pc + 32'd4;
      end
      hold_pending = imem_req && !imem_gnt;
      held_addr    = imem_addr;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle();
    begin_cycle();
    end_cycle();
  endtask

  task automatic do_reset(input int new_lat);
    rst_v = 1'b1; stall_v = 1'b0; redir_v = 1'b0; gnt_mode = 0;
    repeat (2) cycle();
    lat   = new_lat;
    rst_v = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_v = 1'b1; redir_pc_v = target;
    begin_cycle();
    chk("redir_no_req", {31'b0, imem_req}, 32'd0);
    end_cycle();
    redir_v = 1'b0;
  endtask

  task automatic next_delivery(input string tag, input logic [31:0] exp);
    logic ok;
    logic [31:0] pc;
    ok = 1'b0; pc = 32'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      begin_cycle();
      if (if_valid && !stall_v) begin
        ok = 1'b1;
        pc = if_pc;
      end
      end_cycle();
    end
    chk({tag, "_seen"}, {31'b0, ok}, 32'd1);
    chk(tag, pc, exp);
  endtask

  initial begin
    logic ok;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);

    // Reset release with a 1-cycle memory that always grants.
    do_reset(1);
    begin_cycle();
    chk("rel0_valid", {31'b0, if_valid}, 32'd0);
    chk("rel0_req", {31'b0, imem_req}, 32'd1);
    chk("rel0_addr", imem_addr, 32'h0);
    end_cycle();
    begin_cycle();
    chk("rel1_valid", {31'b0, if_valid}, 32'd0);
    chk("rel1_addr", imem_addr, 32'h4);
    end_cycle();
    begin_cycle();
    chk("rel2_valid", {31'b0, if_valid}, 32'd1);
    chk("rel2_pc", if_pc, 32'h0);
    chk("rel2_pc4", if_pc_plus4, 32'h4);
    end_cycle();

    // Streaming, then stall until credits are exhausted, then release.
    repeat (20) cycle();
    stall_v = 1'b1;
    repeat (5) cycle();
    begin_cycle();
    chk("stallfill_req", {31'b0, imem_req}, 32'd0);
    chk("stallfill_valid", {31'b0, if_valid}, 32'd1);
    end_cycle();
    stall_v = 1'b0;
    repeat (10) cycle();

    // Redirect while stalled with a full buffer.
    stall_v = 1'b1;
    repeat (6) cycle();
    redirect_to(32'h0000_1000);
    begin_cycle();
    chk("rs_valid", {31'b0, if_valid}, 32'd0);
    chk("rs_req", {31'b0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr, 32'h0000_1000);
    end_cycle();
    stall_v = 1'b0;
    next_delivery("rs_first", 32'h0000_1000);

    // Redirect with two requests outstanding at 2-cycle latency.
    do_reset(2);
    redirect_to(32'h0000_0010);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (memq.size() == 2) ok = 1'b1;
      else cycle();
    end
    chk("two_outstanding", {31'b0, ok}, 32'd1);
    chk("outst0", memq[0].addr, 32'h10);
    chk("outst1", memq[1].addr, 32'h14);
    redirect_to(32'h0000_0203);
    begin_cycle();
    chk("ri_addr", imem_addr, 32'h0000_0200);
    chk("ri_req", {31'b0, imem_req}, 32'd1);
    end_cycle();
    next_delivery("ri_first", 32'h0000_0200);

    // Grant backpressure keeps the request and address stable.
    do_reset(1);
    gnt_mode = 2;
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      chk("bp_req", {31'b0, imem_req}, 32'd1);
      chk("bp_addr", imem_addr, 32'h0);
      end_cycle();
    end
    gnt_mode = 0;
    cycle();
    begin_cycle();
    chk("bp_next", imem_addr, 32'h4);
    end_cycle();

    // PC wraparound.
    redirect_to(32'hFFFF_FFFE);
    next_delivery("wrap_a", 32'hFFFF_FFFC);
    next_delivery("wrap_b", 32'h0000_0000);

    // Randomised traffic at several memory latencies.
    for (int l = 1; l <= 3; l++) begin
      do_reset(l);
      gnt_mode = 1;
      for (int i = 0; i < 600; i++) begin
        stall_v = ($urandom_range(9) < 3);
        redir_v = ($urandom_range(24) == 0);
        redir_pc_v = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
        cycle();
      end
      redir_v = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of decode. It owns the PC and issues in-order word requests to a request/grant/response instruction memory. Returned instructions are buffered in a small FIFO and presented to the IF/ID boundary with their PC. Branch/jump redirects from execute flush in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FB_DEPTH, 2, fetch-buffer entries; also the maximum number of outstanding imem requests (power of 2, >=2).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hazard unit: decode cannot accept this cycle
redirect_valid  input  1  execute: taken branch/jump this cycle
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address (current PC)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid; responses in request order, >=1 cycle after grant
imem_rdata  input  32  instruction word
if_valid  output  1  if_instruction/if_pc hold a real fetched instruction
if_instruction  output  32  instruction to decode; 32'h00000013 (NOP) when !if_valid
if_pc  output  32  PC of if_instruction; 0 when !if_valid
if_pc_plus4  output  32  if_pc + 4 (mod 2^32)

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, buffer empty, inflight<=0, drop_cnt<=0. imem_req is 0 while rst=1. After reset: if_valid=0, if_instruction=NOP, if_pc=0, if_pc_plus4=4.
- Counters: inflight = granted requests not yet answered (0..FB_DEPTH); drop_cnt = inflight responses to discard (<= inflight).
- Issue: imem_req = !rst && !redirect_valid && (fb_count + inflight - drop_cnt) < FB_DEPTH. imem_addr = pc.
- A handshake is imem_req && imem_gnt: pc<=pc+4 (32-bit wrap, 0xFFFFFFFC -> 0), inflight+1.
- Response (imem_rvalid): inflight-1. If drop_cnt>0 or redirect_valid this cycle: discard, drop_cnt-1 if >0. Else push {pc_of_request, imem_rdata} to the buffer. The PC queue travels with the request, so it is tracked in a FIFO or recomputed as the head PC.
- Simultaneous grant and response in one cycle: inflight unchanged.
- Output: head of buffer is registered; if_valid = !empty. Pop when if_valid && !stall. Push and pop in the same cycle are allowed when full. Credit check guarantees no overflow. A push into an empty buffer is visible the next cycle (no bypass).
- Redirect (priority over stall and issue): pc<=redirect_pc&~3, buffer flushed (if_valid=0 next cycle), drop_cnt <= inflight minus (1 if imem_rvalid this cycle), no request this cycle.
- Redirect latency: redirect at cycle N -> imem_req for target at N+1 -> with 1-cycle memory, rvalid at N+2 -> if_valid with target at N+3.
- stall does not block issue. Fetch continues until credits are exhausted, then imem_req=0.
- imem_gnt=0: imem_req/imem_addr held stable until granted or redirected.
- Reset mid-operation: all counters cleared. Responses to pre-reset requests are not required to be handled; the memory is reset on the same rst.
- Assertions: inflight<=FB_DEPTH; drop_cnt<=inflight; no push when full; no rvalid when inflight==0.

Decomposition:
- defines.vh gains `INST_NOP (32'h00000013) and `RESET_PC_DEFAULT, shared with decode's flush-to-NOP.
- One sub-module, fetch_buffer: synchronous FIFO of {pc[31:0], inst[31:0]}, parameter DEPTH, ports push/pop/flush/full/empty/count, synchronous active-high rst.
- fetch_stage holds the PC, counters and issue logic.

Test Plan:
- Reset: rst high 2 cycles, then low; memory grants always with 1-cycle latency -> imem_addr 0x0,0x4,0x8…; if_valid first at cycle 3 after release with if_pc=0, if_pc_plus4=4.
- Streaming: stall=0, gnt=1, 1-cycle rvalid -> one instruction per cycle, if_pc increments by 4, no bubbles after fill.
- Stall fill: stall=1 for 6 cycles mid-stream -> imem_req drops after buffer+inflight reach 2. if_instruction is held constant. On release, the next two PCs appear in order with none lost.
- Redirect with inflight: 2-cycle memory latency, two requests outstanding (0x10, 0x14), redirect_pc=0x203 -> both responses discarded, next imem_addr=0x200, first if_valid shows if_pc=0x200.
- Redirect and stall together, with buffer full -> buffer flushed, if_valid=0 next cycle, fetch restarts at target.
- Grant backpressure: imem_gnt=0 for 3 cycles with imem_req=1 -> imem_addr stable, pc unchanged. PC wrap test: start at 0xFFFFFFFC -> next fetch 0x0.
